// File: rtl/hazard_enc_pkg.sv
// Shared types and grid-geometry helpers for the streaming hazard grid encoder.
// Bounds are plain ints so callers can compare them at whatever width they need.
package hazard_enc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_t;

    function automatic int row_top(input int r, input int row_h);
        return r * row_h;
    endfunction

    function automatic int col_left(input int c, input int narrow_cols, input int col_w,
                                    input int wide_col_w);
        if (c < narrow_cols)
            return c * col_w;
        return narrow_cols * col_w + (c - narrow_cols) * wide_col_w;
    endfunction

    function automatic int col_right(input int c, input int narrow_cols, input int col_w,
                                     input int wide_col_w);
        return col_left(c, narrow_cols, col_w, wide_col_w)
               + ((c < narrow_cols) ? col_w : wide_col_w) - 1;
    endfunction

    function automatic int num_cells(input int rows, input int cols);
        return rows * cols;
    endfunction

    function automatic int num_words(input int cells, input int word_w);
        return (cells + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/hazard_grid_encoder_seq_cell_mask.sv
// Purpose: combinational hazard box -> grid cell overlap mask (bit r*COLS+c).
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the mask is consumed.
module hazard_cell_mask
    import hazard_enc_pkg::*;
#(
    parameter int ROWS        = 4,
    parameter int ROW_H       = 2,
    parameter int COLS        = 8,
    parameter int NARROW_COLS = 6,
    parameter int COL_W       = 3,
    parameter int WIDE_COL_W  = 4,
    parameter int COORD_W     = 8,
    localparam int NUM_CELLS  = num_cells(ROWS, COLS)
) (
    input  logic [COORD_W-1:0]   top,
    input  logic [COORD_W-1:0]   bottom,
    input  logic [COORD_W-1:0]   left,
    input  logic [COORD_W-1:0]   right,
    output logic [NUM_CELLS-1:0] mask
);

    // Widen everything so coordinates past the grid compare correctly against any bound.
    localparam int CMP_W = (COORD_W > 32) ? COORD_W : 32;

    logic [CMP_W-1:0] t_w, b_w, l_w, r_w;
    logic [CMP_W-1:0] rt, rb, cl, cr;

    assign t_w = CMP_W'(top);
    assign b_w = CMP_W'(bottom);
    assign l_w = CMP_W'(left);
    assign r_w = CMP_W'(right);

    always_comb begin
        mask = '0;
        rt   = '0;
        rb   = '0;
        cl   = '0;
        cr   = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                rt = CMP_W'(row_top(r, ROW_H));
                rb = CMP_W'(row_top(r, ROW_H) + ROW_H - 1);
                cl = CMP_W'(col_left(c, NARROW_COLS, COL_W, WIDE_COL_W));
                cr = CMP_W'(col_right(c, NARROW_COLS, COL_W, WIDE_COL_W));
                mask[r*COLS+c] = !((b_w < rt) || (t_w > rb) || (r_w < cl) || (l_w > cr));
            end
        end
    end

endmodule

// File: rtl/hazard_grid_encoder_seq.sv
// Purpose: accumulate hazard boxes into a per-frame occupancy bitmap, then stream it out as words.
// Latency: first out_valid 1 cycle after the last box is accepted; HAZARD_CNT_EN adds port haz_cnt.
// Backpressure: in_ready low for the whole drain; output words held stable while out_ready is low.
module hazard_grid_encoder_seq
    import hazard_enc_pkg::*;
#(
    parameter int ROWS        = 4,
    parameter int ROW_H       = 2,
    parameter int COLS        = 8,
    parameter int NARROW_COLS = 6,
    parameter int COL_W       = 3,
    parameter int WIDE_COL_W  = 4,
    parameter int COORD_W     = 8,
    parameter int MAX_HAZ     = 16,
    parameter int WORD_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] in_top,
    input  logic [COORD_W-1:0] in_bottom,
    input  logic [COORD_W-1:0] in_left,
    input  logic [COORD_W-1:0] in_right,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORD_W-1:0]  out_data,
    output logic               out_last,
    output logic               overflow,
    output logic               bad_box
`ifdef HAZARD_CNT_EN
    ,
    output logic [$clog2(MAX_HAZ+1)-1:0] haz_cnt
`endif
);

    localparam int NUM_CELLS = num_cells(ROWS, COLS);
    localparam int NUM_WORDS = num_words(NUM_CELLS, WORD_W);
    localparam int PAD_W     = NUM_WORDS * WORD_W;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int CNT_W     = $clog2(MAX_HAZ + 1);

    state_t               state, state_nxt;
    logic [NUM_CELLS-1:0] bitmap;
    logic [NUM_CELLS-1:0] box_mask;
    logic [PAD_W-1:0]     bitmap_pad;
    logic [CNT_W-1:0]     hz_count;
    logic [IDX_W-1:0]     word_idx;
    logic                 frame_start;

    logic accept, malformed, full, merge, drain_hs;

    hazard_cell_mask #(
        .ROWS        (ROWS),
        .ROW_H       (ROW_H),
        .COLS        (COLS),
        .NARROW_COLS (NARROW_COLS),
        .COL_W       (COL_W),
        .WIDE_COL_W  (WIDE_COL_W),
        .COORD_W     (COORD_W)
    ) u_cell_mask (
        .top    (in_top),
        .bottom (in_bottom),
        .left   (in_left),
        .right  (in_right),
        .mask   (box_mask)
    );

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DRAIN);
    assign out_last  = (state == DRAIN) && (word_idx == IDX_W'(NUM_WORDS - 1));

    assign accept    = in_valid && in_ready;
    assign malformed = (in_top > in_bottom) || (in_left > in_right);
    assign full      = (hz_count == CNT_W'(MAX_HAZ));
    assign merge     = accept && !malformed && !full;
    assign drain_hs  = out_valid && out_ready;

    assign bitmap_pad = PAD_W'(bitmap);

    always_comb begin
        out_data = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if ((state == DRAIN) && (word_idx == IDX_W'(k)))
                out_data = bitmap_pad[k*WORD_W +: WORD_W];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (accept && in_last) state_nxt = DRAIN;
            DRAIN:   if (drain_hs && out_last) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ACCUM;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bitmap      <= '0;
            hz_count    <= '0;
            word_idx    <= '0;
            overflow    <= 1'b0;
            bad_box     <= 1'b0;
            frame_start <= 1'b1;
        end else begin
            if (accept) begin
                if (merge) begin
                    bitmap   <= bitmap | box_mask;
                    hz_count <= hz_count + CNT_W'(1);
                end
                // Flags from the previous frame survive until this frame's first box lands.
                overflow    <= (overflow && !frame_start) || full;
                bad_box     <= (bad_box && !frame_start) || malformed;
                frame_start <= 1'b0;
                if (in_last)
                    word_idx <= '0;
            end
            if (drain_hs) begin
                if (out_last) begin
                    bitmap      <= '0;
                    hz_count    <= '0;
                    word_idx    <= '0;
                    frame_start <= 1'b1;
                end else begin
                    word_idx <= word_idx + IDX_W'(1);
                end
            end
        end
    end

`ifdef HAZARD_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            haz_cnt <= '0;
        else if (accept && in_last)
            haz_cnt <= merge ? hz_count + CNT_W'(1) : hz_count;
    end
`endif

endmodule

// File: tb/tb_hazard_grid_encoder_seq.sv
// Bench for hazard_grid_encoder_seq: directed corner frames plus random frames against a pixel-raster model.
module tb_hazard_grid_encoder_seq;

    localparam int NW = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_top, in_bottom, in_left, in_right;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        overflow;
    logic        bad_box;
`ifdef HAZARD_CNT_EN
    logic [4:0]  haz_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    logic [31:0] m_bm;
    int          m_cnt;
    bit          m_ovf, m_bad, m_frame_start;

    hazard_grid_encoder_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_top    (in_top),
        .in_bottom (in_bottom),
        .in_left   (in_left),
        .in_right  (in_right),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .overflow  (overflow),
        .bad_box   (bad_box)
`ifdef HAZARD_CNT_EN
        ,
        .haz_cnt   (haz_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Grid column of pixel x: 6 columns of 3 px, then 2 columns of 4 px (26 px wide).
    function automatic int pix_col(input int x);
        return (x < 18) ? x / 3 : 6 + (x - 18) / 4;
    endfunction

    // Rasterise the box over the 8x26 pixel field and mark every cell a covered pixel falls in.
    function automatic logic [31:0] box_cells(input int t, input int b, input int l, input int r);
        logic [31:0] cells = '0;
        for (int y = t; y <= b && y < 8; y++)
            for (int x = l; x <= r && x < 26; x++)
                cells[(y / 2) * 8 + pix_col(x)] = 1'b1;
        return cells;
    endfunction

    task automatic model_reset();
        m_bm = '0; m_cnt = 0; m_ovf = 0; m_bad = 0; m_frame_start = 1;
    endtask

    task automatic model_accept(input int t, input int b, input int l, input int r);
        bit bad_now;
        bad_now = (t > b) || (l > r);
        if (m_frame_start) begin
            m_ovf = 0; m_bad = 0; m_frame_start = 0;
        end
        if (bad_now) m_bad = 1;
        if (m_cnt == 16) m_ovf = 1;
        if (!bad_now && m_cnt < 16) begin
            m_bm  = m_bm | box_cells(t, b, l, r);
            m_cnt = m_cnt + 1;
        end
    endtask

    // Drive one box and hold it until accepted (inputs change #1 after posedge).
    task automatic send_box(input int t, input int b, input int l, input int r, input bit last);
        int budget = 50;
        in_valid  = 1'b1;
        in_top    = 8'(t);
        in_bottom = 8'(b);
        in_left   = 8'(l);
        in_right  = 8'(r);
        in_last   = last;
        while (!in_ready && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (budget == 0) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_accept(t, b, l, r);
        if (last) begin
            check("drain_latency_out_valid", 32'(out_valid), 32'd1);
            check("drain_in_ready", 32'(in_ready), 32'd0);
            check("overflow_flag", 32'(overflow), 32'(m_ovf));
            check("bad_box_flag", 32'(bad_box), 32'(m_bad));
`ifdef HAZARD_CNT_EN
            check("haz_cnt", 32'(haz_cnt), 32'(m_cnt));
`endif
        end
    endtask

    // Collect all words of the frame, optionally with random out_ready backpressure.
    task automatic drain_frame(input bit rand_bp);
        int k = 0;
        int budget = 200;
        while (k < NW && budget > 0) begin
            out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            check("out_valid", 32'(out_valid), 32'd1);
            check($sformatf("word%0d", k), 32'(out_data), 32'(m_bm[k*16 +: 16]));
            check($sformatf("out_last%0d", k), 32'(out_last), 32'(k == NW - 1));
            @(posedge clk); #1;
            if (out_ready) k++;
            budget--;
        end
        if (budget == 0) check("drain_timeout", 32'(k), 32'(NW));
        out_ready = 1'b1;
        m_bm = '0; m_cnt = 0; m_frame_start = 1;
        check("post_drain_in_ready", 32'(in_ready), 32'd1);
        check("post_drain_out_valid", 32'(out_valid), 32'd0);
        check("post_drain_out_data", 32'(out_data), 32'd0);
        check("post_drain_flags", {30'd0, overflow, bad_box}, {30'd0, m_ovf, m_bad});
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int nb, t, b, l, r;
        rst = 1'b1; in_valid = 0; in_last = 0; out_ready = 1;
        in_top = 0; in_bottom = 0; in_left = 0; in_right = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_bad_box", 32'(bad_box), 32'd0);
`ifdef HAZARD_CNT_EN
        check("rst_haz_cnt", 32'(haz_cnt), 32'd0);
`endif

        // Single corner box -> cell 0
        send_box(0, 1, 0, 2, 1);
        check("corner_word0", 32'(out_data), 32'h0001);
        drain_frame(0);

        // Narrow/wide column boundary -> cells 13,14
        send_box(2, 3, 17, 18, 1);
        check("boundary_word0", 32'(out_data), 32'h6000);
        drain_frame(0);

        // Coordinates running off the grid -> only cell 31
        send_box(6, 255, 25, 255, 1);
        drain_frame(0);

        // 17 boxes: the 17th overflows
        for (int i = 0; i < 17; i++) send_box(0, 1, 0, 2, i == 16);
        check("ovf_set", 32'(overflow), 32'd1);
        drain_frame(0);

        // Malformed box, then a good box clears bad_box
        send_box(3, 1, 0, 0, 1);
        check("bad_set", 32'(bad_box), 32'd1);
        drain_frame(0);
        send_box(4, 5, 9, 9, 0);
        check("bad_cleared", 32'(bad_box), 32'd0);
        check("ovf_cleared", 32'(overflow), 32'd0);
        send_box(0, 0, 20, 20, 1);
        drain_frame(0);

        // Stall word0 for 3 cycles
        send_box(0, 7, 0, 4, 1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_out_data", 32'(out_data), 32'(m_bm[15:0]));
            check("stall_out_last", 32'(out_last), 32'd0);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        drain_frame(0);

        // Reset mid-drain discards the frame
        send_box(0, 7, 0, 25, 1);
        out_ready = 1'b0;
        @(posedge clk); #1;
        pulse_reset();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_data", 32'(out_data), 32'd0);
        out_ready = 1'b1;
        send_box(2, 2, 10, 12, 1);
        drain_frame(0);

        // Random frames with random backpressure
        for (int f = 0; f < 40; f++) begin
            nb = $urandom_range(1, 6);
            for (int i = 0; i < nb; i++) begin
                t = $urandom_range(0, 9);
                b = t + $urandom_range(0, 3);
                l = $urandom_range(0, 30);
                r = l + $urandom_range(0, 6);
                if ($urandom_range(0, 7) == 0) begin
                    int tmp = t; t = b + 1; b = tmp;
                end
                send_box(t, b, l, r, i == nb - 1);
            end
            drain_frame(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
